// File: rtl/vga_mem_arbiter.sv
// Arbitrates the single-port VGA memory bank between the CPU data port and the
// VGA scan-out reader; VGA has priority, bounded by a run limiter.
module vga_mem_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int VGA_MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpuReq,
    input  logic              cpuWrite,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWdata,
    output logic              cpuAck,
    output logic [DATA_W-1:0] cpuRdata,
    output logic              cpuStall,
    input  logic              vgaReq,
    input  logic [ADDR_W-1:0] vgaAddr,
    output logic              vgaAck,
    output logic [DATA_W-1:0] vgaRdata,
    output logic              ramEn,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWdata,
    input  logic [DATA_W-1:0] ramRdata,
    output logic              busy
);
    // state   | meaning
    // IDLE    | arbitrate pending requests, drive grant onto RAM port
    // ACCESS  | RAM samples address/enable at the coming edge
    // CAPTURE | load owner's rdata from RAM, pulse owner's ack
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;

    localparam logic [3:0] MAX_RUN = 4'(VGA_MAX_RUN);

    state_t state, stateNext;
    owner_t owner, ownerNext;
    logic   ownerWrite, ownerWriteNext;
    logic   grantVga, grantCpu;
    logic [3:0] vgaRun, vgaRunNext;

    logic              ramEnNext, ramWeNext, cpuAckNext, vgaAckNext, busyNext;
    logic [ADDR_W-1:0] ramAddrNext;
    logic [DATA_W-1:0] ramWdataNext, cpuRdataNext, vgaRdataNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        grantVga  = 1'b0;
        grantCpu  = 1'b0;
        case (state)
            IDLE: begin
                if (vgaReq && (!cpuReq || vgaRun < MAX_RUN)) grantVga = 1'b1;
                else if (cpuReq)                             grantCpu = 1'b1;
                if (grantVga || grantCpu) stateNext = ACCESS;
            end
            ACCESS:  stateNext = CAPTURE;
            CAPTURE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ramEnNext      = 1'b0;
        ramWeNext      = 1'b0;
        ramAddrNext    = ramAddr;
        ramWdataNext   = ramWdata;
        cpuAckNext     = 1'b0;
        vgaAckNext     = 1'b0;
        cpuRdataNext   = cpuRdata;
        vgaRdataNext   = vgaRdata;
        ownerNext      = owner;
        ownerWriteNext = ownerWrite;
        vgaRunNext     = vgaRun;
        busyNext       = (stateNext != IDLE);
        case (state)
            IDLE: begin
                // Run counts only VGA grants that made a waiting CPU wait longer.
                if (grantCpu || !cpuReq)              vgaRunNext = 4'd0;
                else if (grantVga && vgaRun < MAX_RUN) vgaRunNext = vgaRun + 4'd1;
                if (grantVga) begin
                    ramEnNext      = 1'b1;
                    ramAddrNext    = vgaAddr;
                    ownerNext      = OWN_VGA;
                    ownerWriteNext = 1'b0;
                end else if (grantCpu) begin
                    ramEnNext      = 1'b1;
                    ramWeNext      = cpuWrite;
                    ramAddrNext    = cpuAddr;
                    ramWdataNext   = cpuWdata;
                    ownerNext      = OWN_CPU;
                    ownerWriteNext = cpuWrite;
                end
            end
            CAPTURE: begin
                if (owner == OWN_VGA) begin
                    vgaAckNext   = 1'b1;
                    vgaRdataNext = ramRdata;
                end else if (owner == OWN_CPU) begin
                    cpuAckNext = 1'b1;
                    if (!ownerWrite) cpuRdataNext = ramRdata;
                end
                ownerNext = OWN_NONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramEn      <= 1'b0;
            ramWe      <= 1'b0;
            ramAddr    <= '0;
            ramWdata   <= '0;
            cpuAck     <= 1'b0;
            vgaAck     <= 1'b0;
            cpuRdata   <= '0;
            vgaRdata   <= '0;
            busy       <= 1'b0;
            owner      <= OWN_NONE;
            ownerWrite <= 1'b0;
            vgaRun     <= 4'd0;
        end else begin
            ramEn      <= ramEnNext;
            ramWe      <= ramWeNext;
            ramAddr    <= ramAddrNext;
            ramWdata   <= ramWdataNext;
            cpuAck     <= cpuAckNext;
            vgaAck     <= vgaAckNext;
            cpuRdata   <= cpuRdataNext;
            vgaRdata   <= vgaRdataNext;
            busy       <= busyNext;
            owner      <= ownerNext;
            ownerWrite <= ownerWriteNext;
            vgaRun     <= vgaRunNext;
        end
    end

    assign cpuStall = cpuReq & ~cpuAck;

endmodule
